// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer.
//   - ALU opcode encodings used when driving the execute-stage ALU
//   - iteration counter width
package alu_mul_sequencer_pkg;

  // ALU opcodes. ALU_NOP aliases the AND slot and is driven whenever the
  // sequencer is not issuing an operation, with both operands held at zero.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0110;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_SHL  = 4'b1010;
  localparam logic [3:0] ALU_SHR  = 4'b1100;

  // Iteration counter width. It holds 0..WIDTH-1 and never wraps, because
  // the last iteration is detected at WIDTH-1.
  localparam int CNT_W = 6;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier that borrows the shared 32-bit
// combinational ALU. It serves the otherwise unused MUL opcode slot.
// Each iteration takes three ALU passes: ADD, then SHL, then SHR.
// The parent routes alu_* to the ALU while busy is high.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             job request; only looked at in IDLE
//   mul_a, mul_b      multiplicand and multiplier, latched when a job is accepted
//   busy              high from the cycle after accept through the DONE cycle
//   done              one-cycle pulse; product and ovf are valid from this cycle
//   product           low WIDTH bits of mul_a*mul_b; held until the next accept
//   ovf               sticky flag: the full product does not fit in WIDTH bits
//   alu_A, alu_B      ALU operands (registered)
//   alu_sel           ALU opcode (registered)
//   alu_Cin           ALU carry-in, always 0
//   alu_Y, alu_Cout   ALU result and carry, combinational in the same cycle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; ALU driven with NOP
// ADD   | acc += (mplier[0] ? mcand : 0); an add carry sets ovf
// SHL   | mcand <<= 1; a lost bit sets ovf if higher multiplier bits remain
// SHR   | mplier >>= 1; leave for DONE on the last iteration
// DONE  | done pulse, product valid; back to IDLE
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_sel,
  output logic             alu_Cin,
  input  logic [WIDTH-1:0] alu_Y,
  input  logic             alu_Cout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  assign alu_Cin = 1'b0;

  // In SHR, alu_Y is the next multiplier value. If it is zero, the remaining
  // iterations would only add zero, so early exit can stop here.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && (alu_Y == '0));

  // The ALU operands and opcode are registered. Each transition loads the
  // values that the next state needs, so the ALU sees stable inputs for
  // the whole cycle and alu_Y can be captured at the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      alu_A   <= '0;
      alu_B   <= '0;
      alu_sel <= ALU_NOP;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= '0;
            mcand   <= mul_a;
            mplier  <= mul_b;
            ovf     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            alu_sel <= ALU_ADD;
            alu_A   <= '0;
            alu_B   <= mul_b[0] ? mul_a : '0;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          acc     <= alu_Y;
          ovf     <= ovf | alu_Cout;
          alu_sel <= ALU_SHL;
          alu_A   <= mcand;
          alu_B   <= '0;
          state   <= S_SHL;
        end
        S_SHL: begin
          mcand   <= alu_Y;
          // A bit shifted out of mcand only matters if a later multiplier
          // bit would still add it in.
          ovf     <= ovf | (alu_Cout & (|mplier[WIDTH-1:1]));
          alu_sel <= ALU_SHR;
          alu_A   <= mplier;
          alu_B   <= '0;
          state   <= S_SHR;
        end
        S_SHR: begin
          mplier <= alu_Y;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            // acc is already final, so product is loaded here and is
            // valid in the same cycle as the done pulse.
            product <= acc;
            done    <= 1'b1;
            alu_sel <= ALU_NOP;
            alu_A   <= '0;
            alu_B   <= '0;
            state   <= S_DONE;
          end else begin
            alu_sel <= ALU_ADD;
            alu_A   <= acc;
            alu_B   <= alu_Y[0] ? mcand : '0;
            state   <= S_ADD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          alu_sel <= ALU_NOP;
          alu_A   <= '0;
          alu_B   <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random bench for alu_mul_sequencer. There are two instances:
// one with early exit and one that always runs the full width. Each is
// connected to a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_ee, start_full;
  logic [31:0] mul_a, mul_b;

  logic        busy_ee, done_ee, ovf_ee, alu_cin_ee, alu_cout_ee;
  logic [31:0] product_ee, alu_a_ee, alu_b_ee, alu_y_ee;
  logic [3:0]  alu_sel_ee;

  logic        busy_full, done_full, ovf_full, alu_cin_full, alu_cout_full;
  logic [31:0] product_full, alu_a_full, alu_b_full, alu_y_full;
  logic [3:0]  alu_sel_full;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic done_seen;

  always #5 clk = ~clk;

  // Behavioural model of the execute-stage ALU, limited to the opcodes of interest.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] sel, input logic cin);
    logic [32:0] r;
    r = '0;
    case (sel)
      4'b0000: r = {1'b0, a & b};
      4'b0001: r = {1'b0, a | b};
      4'b0110: r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'b1010: r = {a[31], a[30:0], 1'b0};
      4'b1100: r = {a[0], 1'b0, a[31:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_cout_ee, alu_y_ee}     = alu_model(alu_a_ee, alu_b_ee, alu_sel_ee, alu_cin_ee);
  always_comb {alu_cout_full, alu_y_full} = alu_model(alu_a_full, alu_b_full, alu_sel_full, alu_cin_full);

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst), .start(start_ee), .mul_a(mul_a), .mul_b(mul_b),
    .busy(busy_ee), .done(done_ee), .product(product_ee), .ovf(ovf_ee),
    .alu_A(alu_a_ee), .alu_B(alu_b_ee), .alu_sel(alu_sel_ee), .alu_Cin(alu_cin_ee),
    .alu_Y(alu_y_ee), .alu_Cout(alu_cout_ee)
  );

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .start(start_full), .mul_a(mul_a), .mul_b(mul_b),
    .busy(busy_full), .done(done_full), .product(product_full), .ovf(ovf_full),
    .alu_A(alu_a_full), .alu_B(alu_b_full), .alu_sel(alu_sel_full), .alu_Cin(alu_cin_full),
    .alu_Y(alu_y_full), .alu_Cout(alu_cout_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a job on one instance (0 = early exit, 1 = full width).
  // Returns the cycle of done relative to the accept cycle T0, or 0 on timeout.
  // It returns at the negedge inside the DONE cycle.
  task automatic run_job(input int which, input logic [31:0] a, input logic [31:0] b,
                         output int latency);
    @(negedge clk);
    mul_a = a;
    mul_b = b;
    if (which == 0) start_ee = 1'b1;
    else            start_full = 1'b1;
    latency = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start_ee   = 1'b0;
      start_full = 1'b0;
      if (((which == 0) ? done_ee : done_full) === 1'b1) begin
        latency = i;
        break;
      end
    end
    if (latency == 0) chk("job_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    start_ee   = 1'b0;
    start_full = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy",    busy_ee,    0);
    chk("rst_done",    done_ee,    0);
    chk("rst_product", product_ee, 0);
    chk("rst_ovf",     ovf_ee,     0);
    chk("rst_sel",     alu_sel_ee, 0);
    chk("rst_alu_a",   alu_a_ee,   0);
    chk("rst_alu_b",   alu_b_ee,   0);
    chk("rst_cin",     alu_cin_ee, 0);
    chk("rst_busy_full", busy_full, 0);

    rst = 1'b0;
    @(negedge clk);

    // 6*7, k=3: done at T0+10
    run_job(0, 32'd6, 32'd7, lat);
    chk("t1_latency", lat, 10);
    chk("t1_product", product_ee, 42);
    chk("t1_ovf", ovf_ee, 0);
    chk("t1_busy_in_done", busy_ee, 1);
    @(negedge clk);
    chk("t1_busy_after", busy_ee, 0);
    chk("t1_done_pulse", done_ee, 0);
    chk("t1_product_hold", product_ee, 42);
    chk("t1_idle_sel", alu_sel_ee, 0);

    // multiplier 0: single iteration
    run_job(0, 32'd5, 32'd0, lat);
    chk("t2_latency", lat, 4);
    chk("t2_product", product_ee, 0);
    chk("t2_ovf", ovf_ee, 0);

    // 2^16 * 2^16 wraps to 0 and sets ovf; k=17 -> T0+52
    run_job(0, 32'h0001_0000, 32'h0001_0000, lat);
    chk("t3_latency", lat, 52);
    chk("t3_product", product_ee, 0);
    chk("t3_ovf", ovf_ee, 1);

    // a bit lost on the shift after the last useful multiplier bit must not set ovf
    run_job(0, 32'hFFFF_FFFF, 32'd1, lat);
    chk("t3b_latency", lat, 4);
    chk("t3b_product", product_ee, 32'hFFFF_FFFF);
    chk("t3b_ovf", ovf_ee, 0);

    // start pulsed while busy is ignored
    @(negedge clk);
    mul_a = 32'd6; mul_b = 32'd7; start_ee = 1'b1;
    @(negedge clk);                             // T0+1, ADD
    start_ee = 1'b0;
    chk("t4_busy", busy_ee, 1);
    chk("t4_add_sel", alu_sel_ee, 4'b0110);
    chk("t4_add_b", alu_b_ee, 6);
    @(negedge clk);                             // T0+2, SHL
    chk("t4_shl_sel", alu_sel_ee, 4'b1010);
    chk("t4_shl_a", alu_a_ee, 6);
    mul_a = 32'd9; mul_b = 32'd9; start_ee = 1'b1;
    @(negedge clk);                             // T0+3, SHR
    start_ee = 1'b0;
    chk("t4_shr_sel", alu_sel_ee, 4'b1100);
    lat = 0;
    for (int i = 4; i <= 200; i++) begin
      @(negedge clk);
      if (done_ee === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("t4_latency", lat, 10);
    chk("t4_product", product_ee, 42);
    repeat (3) @(negedge clk);
    chk("t4_no_queue", busy_ee, 0);

    // reset during a job: the job is dropped and no done is issued
    mul_a = 32'd4; mul_b = 32'h0000_00FF; start_ee = 1'b1;
    done_seen = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start_ee = 1'b0;
      if (done_ee === 1'b1) done_seen = 1'b1;
    end
    rst = 1'b1;                                 // asserted in cycle T0+5
    @(negedge clk);
    chk("t4r_busy", busy_ee, 0);
    chk("t4r_product", product_ee, 0);
    chk("t4r_done", done_ee, 0);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_ee === 1'b1) done_seen = 1'b1;
    end
    chk("t4r_no_done", done_seen, 0);

    run_job(0, 32'd3, 32'd9, lat);
    chk("t4r_latency", lat, 13);
    chk("t4r_product27", product_ee, 27);

    // full-width instance always runs 32 iterations
    run_job(1, 32'd2, 32'd3, lat);
    chk("t5_latency", lat, 97);
    chk("t5_product", product_full, 6);
    chk("t5_ovf", ovf_full, 0);

    // random pairs; the multiplier is kept narrow to bound run time
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] full;
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(16, 31);
      full = {32'd0, ra} * {32'd0, rb};
      run_job(0, ra, rb, lat);
      chk("rnd_product", product_ee, full[31:0]);
      chk("rnd_ovf", ovf_ee, |full[63:32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
